// File: rtl/multiplier_seq_ctrl_if.sv
// Requester-side bundle for the sequential multiplier controller: start
// request with operands in one direction, status and result in the other.
interface multiplier_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start,
        output multiplicand,
        output multiplier,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  multiplicand,
        input  multiplier,
        output busy,
        output done,
        output product
    );
endinterface

// File: rtl/multiplier_seq_ctrl.sv
// Sequential WIDTH x WIDTH unsigned multiplier. One shared 2x2 gate-level
// multiplier is stepped over every pair of 2-bit operand digits, one pair
// per cycle, and each shifted partial product is summed into an accumulator.
// The final partial sum is written straight into the product register on
// the last-pair edge, so the result appears D*D cycles after start.

// 2x2 unsigned multiplier built from AND/XOR gates (two half adders).
module multiplier2x2 (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic [3:0] p_o
);
    logic a0b0, a1b0, a0b1, a1b1, c1;

    assign a0b0 = a_i[0] & b_i[0];
    assign a1b0 = a_i[1] & b_i[0];
    assign a0b1 = a_i[0] & b_i[1];
    assign a1b1 = a_i[1] & b_i[1];
    assign c1   = a1b0 & a0b1;

    assign p_o[0] = a0b0;
    assign p_o[1] = a1b0 ^ a0b1;
    assign p_o[2] = a1b1 ^ c1;
    assign p_o[3] = a1b1 & c1;
endmodule

module multiplier_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    multiplier_seq_ctrl_if.slave  bus
);
    localparam int D     = WIDTH / 2;
    localparam int PW    = 2 * WIDTH;
    localparam int IDX_W = (D > 1) ? $clog2(D) : 1;

    localparam logic [IDX_W-1:0] DMAX = IDX_W'(D - 1);

    typedef logic [PW-1:0] acc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    acc_t               acc_q, acc_d;
    acc_t               product_q, product_d;
    logic [IDX_W-1:0]   i_q, i_d;
    logic [IDX_W-1:0]   j_q, j_d;

    logic [1:0]         a_dig;
    logic [1:0]         b_dig;
    logic [3:0]         pp;
    logic [IDX_W+1:0]   sh;
    acc_t               pp_ext;
    acc_t               sum;
    logic               last_pair;

    // Current digit pair: i selects the multiplicand digit, j the multiplier digit.
    assign a_dig     = a_q[2*i_q +: 2];
    assign b_dig     = b_q[2*j_q +: 2];
    assign sh        = {1'b0, i_q, 1'b0} + {1'b0, j_q, 1'b0};
    assign pp_ext    = acc_t'(pp) << sh;
    assign sum       = acc_q + pp_ext;
    assign last_pair = (i_q == DMAX) && (j_q == DMAX);

    multiplier2x2 u_mul2x2 (
        .a_i (a_dig),
        .b_i (b_dig),
        .p_o (pp)
    );

    // Status outputs decode directly from the state register.
    assign bus.busy    = (state_q == RUN);
    assign bus.done    = (state_q == DONE);
    assign bus.product = product_q;

    // Next-state, operand latch, digit stepping and accumulation.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        i_d       = i_q;
        j_d       = j_q;
        product_d = product_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    a_d     = bus.multiplicand;
                    b_d     = bus.multiplier;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            RUN: begin
                acc_d = sum;
                if (last_pair) begin
                    // Final sum bypasses the accumulator to save a cycle.
                    product_d = sum;
                    state_d   = DONE;
                end else if (i_q == DMAX) begin
                    i_d = '0;
                    j_d = j_q + 1'b1;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            i_q       <= i_d;
            j_q       <= j_d;
            product_q <= product_d;
        end
    end
endmodule

// File: tb/tb_multiplier_seq_ctrl.sv
// Directed bench for multiplier_seq_ctrl: a WIDTH=8 instance for the
// handshake scenarios and a WIDTH=4 instance for the exhaustive sweep.
module tb_multiplier_seq_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multiplier_seq_ctrl_if #(.WIDTH(8)) bus8 ();
    multiplier_seq_ctrl_if #(.WIDTH(4)) bus4 ();

    multiplier_seq_ctrl #(.WIDTH(8)) dut8 (
        .clock (clk),
        .reset (rst),
        .bus   (bus8)
    );

    multiplier_seq_ctrl #(.WIDTH(4)) dut4 (
        .clock (clk),
        .reset (rst),
        .bus   (bus4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // From the current negedge, count busy cycles until done is seen.
    task automatic wait_done8(input string tag, input logic [31:0] exp_prod, input int exp_busy);
        int cnt;
        bit found;
        cnt   = 0;
        found = 1'b0;
        for (int c = 0; c < 64; c++) begin
            if (bus8.done === 1'b1) begin
                found = 1'b1;
                break;
            end
            if (bus8.busy === 1'b1) cnt++;
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 32'(found), 32'd1);
        check({tag, "_busy_cycles"}, cnt, exp_busy);
        check({tag, "_busy_at_done"}, 32'(bus8.busy), 32'd0);
        check({tag, "_product"}, 32'(bus8.product), exp_prod);
    endtask

    task automatic run_op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [31:0] exp_prod);
        @(negedge clk);
        bus8.multiplicand = a;
        bus8.multiplier   = b;
        bus8.start        = 1'b1;
        @(negedge clk);
        bus8.start        = 1'b0;
        wait_done8(tag, exp_prod, 16);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        bus8.start        = 1'b0;
        bus8.multiplicand = '0;
        bus8.multiplier   = '0;
        bus4.start        = 1'b0;
        bus4.multiplicand = '0;
        bus4.multiplier   = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus8.busy), 32'd0);
        check("rst_done", 32'(bus8.done), 32'd0);
        check("rst_product", 32'(bus8.product), 32'd0);
        check("rst_w4_busy", 32'(bus4.busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 13 * 11 = 143, done is a single-cycle pulse
        run_op8("t1", 8'd13, 8'd11, 32'h008F);
        @(negedge clk);
        check("t1_done_pulse", 32'(bus8.done), 32'd0);
        check("t1_product_hold", 32'(bus8.product), 32'h008F);

        // 255 * 255, then 0 * 200 with the old result held during RUN
        run_op8("t2a", 8'd255, 8'd255, 32'hFE01);
        @(negedge clk);
        bus8.multiplicand = 8'd0;
        bus8.multiplier   = 8'd200;
        bus8.start        = 1'b1;
        @(negedge clk);
        bus8.start        = 1'b0;
        repeat (5) @(negedge clk);
        check("t2b_busy_mid", 32'(bus8.busy), 32'd1);
        check("t2b_product_hold", 32'(bus8.product), 32'hFE01);
        wait_done8("t2b", 32'h0000, 11);
        @(negedge clk);

        // start held high, operands changed during RUN
        bus8.multiplicand = 8'd3;
        bus8.multiplier   = 8'd5;
        bus8.start        = 1'b1;
        @(negedge clk);
        bus8.multiplicand = 8'd7;
        bus8.multiplier   = 8'd9;
        wait_done8("t3a", 32'd15, 16);
        @(negedge clk);
        check("t3_idle_busy", 32'(bus8.busy), 32'd0);
        check("t3_idle_done", 32'(bus8.done), 32'd0);
        @(negedge clk);
        bus8.start = 1'b0;
        wait_done8("t3b", 32'd63, 16);
        @(negedge clk);

        // asynchronous reset in the 7th RUN cycle
        bus8.multiplicand = 8'd100;
        bus8.multiplier   = 8'd200;
        bus8.start        = 1'b1;
        @(negedge clk);
        bus8.start        = 1'b0;
        repeat (6) @(negedge clk);
        check("t4_busy_before", 32'(bus8.busy), 32'd1);
        check("t4_product_before", 32'(bus8.product), 32'd63);
        #2;
        rst = 1'b1;
        #1;
        check("t4_busy_async", 32'(bus8.busy), 32'd0);
        check("t4_done_async", 32'(bus8.done), 32'd0);
        check("t4_product_async", 32'(bus8.product), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t4_busy_after_release", 32'(bus8.busy), 32'd0);
        run_op8("t4b", 8'd2, 8'd3, 32'd6);
        @(negedge clk);

        // start pulsed during the DONE cycle is ignored
        run_op8("t6", 8'd6, 8'd7, 32'd42);
        bus8.multiplicand = 8'd9;
        bus8.multiplier   = 8'd9;
        bus8.start        = 1'b1;
        @(negedge clk);
        bus8.start        = 1'b0;
        check("t6_busy_after_done", 32'(bus8.busy), 32'd0);
        check("t6_done_after_done", 32'(bus8.done), 32'd0);
        @(negedge clk);
        check("t6_busy_idle", 32'(bus8.busy), 32'd0);
        check("t6_done_idle", 32'(bus8.done), 32'd0);
        check("t6_product_idle", 32'(bus8.product), 32'd42);

        // WIDTH=4 exhaustive back-to-back sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                int  cnt;
                bit  found;
                bus4.multiplicand = 4'(a);
                bus4.multiplier   = 4'(b);
                bus4.start        = 1'b1;
                @(negedge clk);
                bus4.start        = 1'b0;
                cnt   = 0;
                found = 1'b0;
                for (int c = 0; c < 16; c++) begin
                    if (bus4.done === 1'b1) begin
                        found = 1'b1;
                        break;
                    end
                    if (bus4.busy === 1'b1) cnt++;
                    @(negedge clk);
                end
                check($sformatf("w4_done_seen_%0d_%0d", a, b), 32'(found), 32'd1);
                check($sformatf("w4_busy_%0d_%0d", a, b), cnt, 32'd4);
                check($sformatf("w4_prod_%0d_%0d", a, b), 32'(bus4.product), 32'(a * b));
                @(negedge clk);
                check($sformatf("w4_done_once_%0d_%0d", a, b), 32'(bus4.done), 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multiplier_seq_ctrl.md
# multiplier_seq_ctrl

Sequential multiplier controller that computes a WIDTH x WIDTH unsigned product by time-sharing one `multiplier2x2` gate-level instance. It steps through every pair of 2-bit digits, one pair per cycle, and adds each shifted 4-bit partial product into an accumulator. It sits between a requester issuing start/operand transactions and the 2x2 multiplier datapath, and owns all sequencing, latching and handshake.

## Interface
- `WIDTH`, default 8: operand width in bits. Must be even, 2..16. D = WIDTH/2 digits per operand.
- `clock` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: request a multiplication. Sampled on the rising edge, accepted only in IDLE.
- `multiplicand` input WIDTH: operand A. Latched on the accepted start edge.
- `multiplier` input WIDTH: operand B. Latched on the accepted start edge.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse; `product` is valid and newly updated.
- `product` output 2*WIDTH: registered result. Holds until the next completion.

## Operation
- States:
  - IDLE: `busy`=0, `done`=0.
  - RUN: `busy`=1, `done`=0.
  - DONE: `busy`=0, `done`=1.
- Transitions:
  - IDLE -> RUN on a clock edge with `start`=1.
  - RUN -> DONE on the edge that processes the last digit pair.
  - DONE -> IDLE unconditionally on the next edge.
- On the accepting edge:
  - latch A and B into internal registers;
  - clear the accumulator (2*WIDTH bits);
  - set digit indices i=0 (A digit), j=0 (B digit).
- Each RUN cycle, the shared `multiplier2x2` receives A[2i+1:2i] and B[2j+1:2j]. Its 4-bit output, zero-extended and shifted left by 2*(i+j), is added to the accumulator on the edge.
- Index order: i increments fastest. When i=D-1, i wraps to 0 and j increments. The pair (i=D-1, j=D-1) is last.
- On the last-pair edge, the final sum (accumulator + last partial product) is written to `product` directly. No extra cycle is spent.
- Arithmetic:
  - unsigned;
  - accumulator addition is modulo 2^(2*WIDTH);
  - the true product always fits, so wrap never occurs for legal operands.
- `start` in RUN or DONE is ignored. It is not queued, and operand input changes in those states have no effect.
- `start` held high continuously: a new operation is accepted on the first edge in IDLE after DONE.
- `product` is not cleared by a new start. The old result stays visible until the new completion.
- Reset asserted at any time, including mid-RUN:
  - immediately forces IDLE;
  - `busy`=0, `done`=0, `product`=0;
  - accumulator, operand registers and indices cleared;
  - the in-flight result is discarded.
- Operation resumes with the first `start` edge after reset deasserts.

## Timing
- Reset values: `busy`=0, `done`=0, `product`=0, state IDLE.
- Start accepted at edge k:
  - `busy`=1 from after edge k through edge k+D*D;
  - `product` updated and `done`=1 after edge k+D*D;
  - `done` deasserts after edge k+D*D+1.
- Latency is D*D cycles from start to result (16 for WIDTH=8, 4 for WIDTH=4).
- The earliest next accepted start is edge k+D*D+2, so throughput is one operation per D*D+2 cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- WIDTH=8, reset, then start with A=13, B=11:
  - `busy` high for 16 cycles;
  - `done` pulses once after edge k+16;
  - `product`=143 (16'h008F).
- WIDTH=8, A=255, B=255 -> `product`=65025 (16'hFE01) after 16 cycles. Then A=0, B=200 -> `product` stays 16'hFE01 until the new done, then 0.
- Hold `start`=1 continuously with A=3, B=5, and change operands to A=7, B=9 during RUN:
  - first done gives 15;
  - the second operation is accepted at edge k+18 with the latched 7, 9, and gives 63 at edge k+34.
- Start A=100, B=200, assert `reset` asynchronously mid-clock during RUN cycle 7:
  - `busy`, `done` and `product` go to 0 immediately, without waiting for an edge;
  - after release, start A=2, B=3 -> `product`=6 after 16 cycles.
- WIDTH=4, sweep all 256 operand pairs back-to-back:
  - each result equals A*B;
  - `busy` is high exactly 4 cycles per operation;
  - exactly one `done` per operation.
- Pulse `start` while in the DONE cycle -> ignored: no second operation, `busy` stays 0, next IDLE cycle idle.
